mask_load_ctrl: RTL

MASK_LOAD_CTRL -- requirements
Module: mask_load_ctrl

---
 rtl/mask_ctrl_pkg.sv | 6 +
 rtl/rr_arb2.sv | 18 +
 rtl/mask_load_ctrl.sv | 84 ++++++++
 3 files changed

// File: rtl/mask_ctrl_pkg.sv
// mask_ctrl_pkg: FSM state type and grant-source encoding shared by the mask load controller
package mask_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, PIM_WR, MOV_WR} state_t;
    localparam int SRC_PIM = 0;
    localparam int SRC_MOV = 1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; the pointer moves to the loser after every grant taken
module rr_arb2 import mask_ctrl_pkg::*; (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    logic ptr_q, ptr_d;
    always_comb begin
        gnt[SRC_PIM] = req[SRC_PIM] & (~req[SRC_MOV] | ptr_q == 1'(SRC_PIM));
        gnt[SRC_MOV] = req[SRC_MOV] & (~req[SRC_PIM] | ptr_q == 1'(SRC_MOV));
        ptr_d = (advance & |gnt) ? (gnt[SRC_PIM] ? 1'(SRC_MOV) : 1'(SRC_PIM)) : ptr_q;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr_q <= 1'(SRC_PIM);
        else        ptr_q <= ptr_d;
endmodule

// File: rtl/mask_load_ctrl.sv
// mask_load_ctrl: arbitrates PIM single writes and MOV bursts into the mask register load strobes
module mask_load_ctrl import mask_ctrl_pkg::*; #(
    parameter int N     = 10,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pim_req,
    input  logic [N-1:0]     pim_data,
    output logic             pim_ack,
    input  logic             mov_req,
    input  logic [LEN_W-1:0] mov_len,
    input  logic [N-1:0]     mov_data,
    input  logic             mov_abort,
    output logic             mov_ack,
    output logic             mov_done,
    output logic             PIM_load,
    output logic             Mov_load,
    output logic [N-1:0]     D,
    output logic [N-1:0]     MOV_in,
    output logic             busy
);
    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     d_q, d_d;
    logic [1:0]       req, gnt;
    logic             idle, in_mov, last;
    assign idle   = state_q == IDLE;
    assign in_mov = state_q == MOV_WR;
    assign last   = cnt_q == LEN_W'(1);
    always_comb begin
        req          = '0;
        req[SRC_PIM] = pim_req;
        req[SRC_MOV] = mov_req;
    end
    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (idle),
        .gnt     (gnt)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        case (state_q)
            IDLE: begin
                if (gnt[SRC_PIM]) begin
                    d_d     = pim_data;
                    state_d = PIM_WR;
                end else if (gnt[SRC_MOV]) begin
                    // a zero-length burst still carries one beat
                    cnt_d   = (mov_len == '0) ? LEN_W'(1) : mov_len;
                    state_d = MOV_WR;
                end
            end
            PIM_WR: state_d = IDLE;
            MOV_WR: begin
                cnt_d = mov_abort ? '0 : cnt_q - 1'b1;
                if (mov_abort || last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
        end
    assign busy     = !idle;
    assign PIM_load = state_q == PIM_WR;
    assign pim_ack  = PIM_load;
    assign Mov_load = in_mov & ~mov_abort;
    assign mov_ack  = Mov_load;
    assign mov_done = in_mov & (mov_abort | last);
    assign D        = d_q;
    assign MOV_in   = mov_data;
endmodule
